// File: rtl/bullet_if.sv
// ----------------------------------------------------------------------------
// bullet_if
// Signal bundle between the player-bullet controller and its surroundings.
//   i_fire          : debounced fire button (level)
//   i_player_x      : player column, 0..19 (larger values clamp to 19)
//   i_hit           : hit flag from the invaders block
//   o_bullet_x      : bullet column
//   o_bullet_y      : bullet row, 0 = parked / off-field
//   o_bullet_active : shot in flight
//   o_score         : saturating hit count
// Modports: master drives the inputs and observes the outputs; slave is the
// bullet controller itself.
// ----------------------------------------------------------------------------
interface bullet_if;
    logic       i_fire;
    logic [4:0] i_player_x;
    logic       i_hit;
    logic [4:0] o_bullet_x;
    logic [3:0] o_bullet_y;
    logic       o_bullet_active;
    logic [7:0] o_score;

    modport master (
        output i_fire, i_player_x, i_hit,
        input  o_bullet_x, o_bullet_y, o_bullet_active, o_score
    );

    modport slave (
        input  i_fire, i_player_x, i_hit,
        output o_bullet_x, o_bullet_y, o_bullet_active, o_score
    );
endinterface

// File: rtl/bullet.sv
// ----------------------------------------------------------------------------
// bullet
// Player-bullet controller. Launches a shot from the player's column on a
// rising fire edge, steps it up one row per divider tick, retires it on a
// rising hit edge (scoring) or when it leaves the top row (miss), then waits
// COOLDOWN_TICKS ticks before another shot may be fired.
// Ports:
//   i_clk_25MHz : system clock
//   i_reset     : synchronous, active-high reset
//   bus         : bullet_if.slave (fire/player_x/hit in; bullet x/y/active,
//                 score out). All outputs are registered.
// Parameters:
//   SPEED          : clocks per bullet step (>= 2)
//   COOLDOWN_TICKS : ticks after retirement before a new shot (>= 1)
// ----------------------------------------------------------------------------
module bullet #(
    parameter int SPEED          = 100000,
    parameter int COOLDOWN_TICKS = 2
) (
    input  logic     i_clk_25MHz,
    input  logic     i_reset,
    bullet_if.slave  bus
);

    localparam int CW = (SPEED > 1) ? $clog2(SPEED) : 1;
    localparam int KW = $clog2(COOLDOWN_TICKS + 1);

    localparam logic [4:0] X_MAX     = 5'd19;
    localparam logic [3:0] Y_LAUNCH  = 4'd14;
    localparam logic [7:0] SCORE_MAX = 8'd255;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLYING   = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_t;

    state_t          r_state_reg,   w_state_next;
    logic [4:0]      r_x_reg,       w_x_next;
    logic [3:0]      r_y_reg,       w_y_next;
    logic            r_active_reg,  w_active_next;
    logic [7:0]      r_score_reg,   w_score_next;
    logic [KW-1:0]   r_cool_reg,    w_cool_next;
    logic [CW-1:0]   r_tick_cnt_reg;
    logic            r_fire_prev_reg;
    logic            r_hit_prev_reg;

    logic            w_tick;
    logic            w_fire_edge;
    logic            w_hit_edge;
    logic [4:0]      w_player_x_clamped;

    // ------------------------------------------------------------------
    // Step divider: one-clock tick when the counter sits at SPEED-1.
    // ------------------------------------------------------------------
    assign w_tick = (r_tick_cnt_reg == CW'(SPEED - 1));

    always_ff @(posedge i_clk_25MHz) begin
        if (i_reset) begin
            r_tick_cnt_reg <= '0;
        end else if (w_tick) begin
            r_tick_cnt_reg <= '0;
        end else begin
            r_tick_cnt_reg <= r_tick_cnt_reg + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Edge detectors. The fire history resets high so a button held
    // through reset does not launch a shot on release of reset.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk_25MHz) begin
        if (i_reset) begin
            r_fire_prev_reg <= 1'b1;
            r_hit_prev_reg  <= 1'b0;
        end else begin
            r_fire_prev_reg <= bus.i_fire;
            r_hit_prev_reg  <= bus.i_hit;
        end
    end

    assign w_fire_edge = bus.i_fire & ~r_fire_prev_reg;
    assign w_hit_edge  = bus.i_hit  & ~r_hit_prev_reg;

    assign w_player_x_clamped = (bus.i_player_x > X_MAX) ? X_MAX : bus.i_player_x;

    // ------------------------------------------------------------------
    // State and output registers.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk_25MHz) begin
        if (i_reset) begin
            r_state_reg  <= ST_IDLE;
            r_x_reg      <= '0;
            r_y_reg      <= '0;
            r_active_reg <= 1'b0;
            r_score_reg  <= '0;
            r_cool_reg   <= '0;
        end else begin
            r_state_reg  <= w_state_next;
            r_x_reg      <= w_x_next;
            r_y_reg      <= w_y_next;
            r_active_reg <= w_active_next;
            r_score_reg  <= w_score_next;
            r_cool_reg   <= w_cool_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. A hit edge takes priority over a tick in FLYING so
    // a shot that hits is never moved past its target row before retiring.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state_reg;
        w_x_next      = r_x_reg;
        w_y_next      = r_y_reg;
        w_active_next = 1'b0;
        w_score_next  = r_score_reg;
        w_cool_next   = r_cool_reg;

        case (r_state_reg)
            ST_IDLE: begin
                w_x_next = w_player_x_clamped;
                w_y_next = '0;
                if (w_fire_edge) begin
                    w_state_next  = ST_FLYING;
                    w_y_next      = Y_LAUNCH;
                    w_active_next = 1'b1;
                end
            end

            ST_FLYING: begin
                w_active_next = 1'b1;
                if (w_hit_edge) begin
                    w_state_next  = ST_COOLDOWN;
                    w_y_next      = '0;
                    w_active_next = 1'b0;
                    w_cool_next   = KW'(COOLDOWN_TICKS);
                    if (r_score_reg != SCORE_MAX) begin
                        w_score_next = r_score_reg + 1'b1;
                    end
                end else if (w_tick) begin
                    if (r_y_reg > 4'd1) begin
                        w_y_next = r_y_reg - 1'b1;
                    end else begin
                        // Stepping off row 1 leaves the field: a miss.
                        w_state_next  = ST_COOLDOWN;
                        w_y_next      = '0;
                        w_active_next = 1'b0;
                        w_cool_next   = KW'(COOLDOWN_TICKS);
                    end
                end
            end

            ST_COOLDOWN: begin
                w_y_next = '0;
                if (w_tick) begin
                    if (r_cool_reg <= KW'(1)) begin
                        w_state_next = ST_IDLE;
                        w_cool_next  = '0;
                    end else begin
                        w_cool_next  = r_cool_reg - 1'b1;
                    end
                end
            end

            default: begin
                w_state_next = ST_IDLE;
                w_y_next     = '0;
            end
        endcase
    end

    assign bus.o_bullet_x      = r_x_reg;
    assign bus.o_bullet_y      = r_y_reg;
    assign bus.o_bullet_active = r_active_reg;
    assign bus.o_score         = r_score_reg;

endmodule

// File: doc/bullet.md
# bullet

Player-bullet controller that sits directly upstream of the invaders block. It launches a shot from the player's column on a fire-button press and steps it up the 20×16 playfield grid on a fixed tick. It drives the bullet coordinates the invaders block compares against its formation, and retires the shot when the invaders block reports a hit or the shot leaves the top of the field. It also keeps a saturating hit score.

## Interface
Parameters:
- SPEED, 100000 — clocks per bullet step; internal divider period, ≥ 2.
- COOLDOWN_TICKS, 2 — ticks after retirement before a new shot is accepted, ≥ 1.

Ports:
- i_clk_25MHz  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_fire  in  1  fire button, already debounced and synchronised; level.
- i_player_x  in  5  player column, 0..19; values > 19 treated as 19.
- i_hit  in  1  hit flag from the invaders block; may stay high for several cycles per hit.
- o_bullet_x  out  5  bullet column.
- o_bullet_y  out  4  bullet row; 0 = parked/off-field.
- o_bullet_active  out  1  shot in flight.
- o_score  out  8  hits counted, saturates at 255.

## Operation
- Tick divider: counter 0..SPEED-1, cleared by reset. The tick pulse lasts one clock when the counter equals SPEED-1, then the counter wraps to 0.
- Fire edge: i_fire high now and low on the previous cycle; the previous-value register resets to 1.
- Hit edge: i_hit high now and low on the previous cycle; the previous-value register resets to 0.
- State machine, one-hot or encoded; reset state IDLE.
  - IDLE:
    - o_bullet_y = 0, o_bullet_active = 0.
    - o_bullet_x tracks clamp(i_player_x), registered.
    - A fire edge goes to FLYING: x latched from clamp(i_player_x), y = 14.
    - Tick and hit edges are ignored.
  - FLYING:
    - o_bullet_active = 1; x is held.
    - Hit edge: go to COOLDOWN, y = 0, and increment o_score unless it is already 255.
    - Otherwise, tick with y > 1: y = y-1.
    - Otherwise, tick with y == 1: go to COOLDOWN, y = 0, no score change (miss).
    - A hit edge and a tick in the same cycle count as a hit; the tick is discarded.
    - Fire edges are ignored.
  - COOLDOWN:
    - o_bullet_active = 0, y = 0.
    - The internal count is loaded with COOLDOWN_TICKS on entry and decrements on each tick.
    - Go to IDLE on the tick that brings the count to 0.
    - Fire and hit edges are ignored; a fire edge is not queued.
- Row 0 is never a target row: the invaders formation row is ≥ 1, so it compares against row+1 ≥ 2. A parked bullet cannot score.
- Reset mid-flight: the shot is discarded and all state returns to reset values. The score is cleared.

## Timing
- Reset values:
  - o_bullet_x = 0, o_bullet_y = 0, o_bullet_active = 0, o_score = 0.
  - State IDLE, tick counter 0.
- Launch latency: a fire edge sampled at clock edge N gives FLYING outputs (y = 14, active = 1) valid after edge N.
- Step: y changes on the same edge that samples tick, so there is one row per SPEED clocks.
- Hit path:
  - The invaders block registers o_hit one clock after seeing the matching coordinates.
  - This block retires on the edge that samples that rising hit.
  - The bullet therefore holds its coordinates for at least the clock in which the hit is detected. A tick arriving in that same clock may move y once before retirement; this is acceptable.
- Full flight with no hit: 14 ticks from launch to retire (rows 14..1, then 0).
- All outputs are registered; no combinational input-to-output paths.

## Test plan
Run all scenarios with SPEED = 4, COOLDOWN_TICKS = 2.
- Reset then idle: i_player_x = 7 for 10 clocks -> o_bullet_x = 7, y = 0, active = 0, score = 0; i_player_x = 25 -> x = 19.
- Single shot, miss: fire pulse at x = 3 -> next clock y = 14, active = 1. y decrements every 4 clocks to 1, then returns to 0 with active = 0. Score stays 0. IDLE is re-entered 8 clocks later.
- Hit: launch, then raise i_hit for 3 clocks while y = 9 -> retire on the first edge, score = 1 (not 3), y = 0 the next cycle.
- Simultaneous hit edge and tick -> score increments and y goes to 0, not y-1.
- Fire held high or pulsed during FLYING/COOLDOWN -> no relaunch. Holding through IDLE entry does not fire; a fresh low-to-high edge does.
- Reset asserted at y = 6 -> next clock all outputs at reset values. Also: force score to 255 and hit -> score stays 255.
